// File: rtl/cell_minmax_stat.sv
// Per-cell pixel statistics: per-channel min/max/range over CELL_LEN valid beats,
// plus the cross-channel minimum (dark value) of the selected statistic.
module cell_minmax_stat #(
  parameter int CH_NUM   = 3,
  parameter int CH_W     = 8,
  parameter int CELL_LEN = 24,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [1:0]               mode,
  input  logic                     in_sync,
  input  logic                     in_valid,
  input  logic [CH_NUM*CH_W-1:0]   in_data,
  output logic                     out_valid,
  output logic [CH_NUM*CH_W-1:0]   out_data,
  output logic [CH_W-1:0]          out_dark,
  output logic [CNT_W-1:0]         out_cell_idx
);

  localparam int PW = CH_NUM * CH_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CELL_LEN - 1);

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] cell_q, cell_d;
  logic [PW-1:0]    min_q, min_d;
  logic [PW-1:0]    max_q, max_d;
  logic [1:0]       mode_q, mode_d;

  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_data_q, out_data_d;
  logic [CH_W-1:0]  out_dark_q, out_dark_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;

  // A sync pulse makes the current cycle look like the start of a fresh cell.
  logic [CNT_W-1:0] bcnt_eff, cell_eff;
  logic             first_beat, last_beat;
  logic [1:0]       mode_eff;

  assign bcnt_eff   = in_sync ? '0 : bcnt_q;
  assign cell_eff   = in_sync ? '0 : cell_q;
  assign first_beat = (bcnt_eff == '0);
  assign last_beat  = (bcnt_eff == LAST_BEAT);
  assign mode_eff   = first_beat ? mode : mode_q;

  logic [PW-1:0]   min_new, max_new, sel_new;
  logic [CH_W-1:0] dark_chain [0:CH_NUM];

  assign dark_chain[0] = '1;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [CH_W-1:0] px, mn, mx, rng, sel;

      assign px  = in_data[gi*CH_W +: CH_W];
      assign mn  = (first_beat || (px < min_q[gi*CH_W +: CH_W])) ? px : min_q[gi*CH_W +: CH_W];
      assign mx  = (first_beat || (px > max_q[gi*CH_W +: CH_W])) ? px : max_q[gi*CH_W +: CH_W];
      assign rng = mx - mn;
      assign sel = (mode_eff == 2'd1) ? mx : (mode_eff == 2'd2) ? rng : mn;

      assign min_new[gi*CH_W +: CH_W] = mn;
      assign max_new[gi*CH_W +: CH_W] = mx;
      assign sel_new[gi*CH_W +: CH_W] = sel;
      assign dark_chain[gi+1] = (sel < dark_chain[gi]) ? sel : dark_chain[gi];
    end
  endgenerate

  always_comb begin
    bcnt_d      = bcnt_eff;
    cell_d      = cell_eff;
    min_d       = min_q;
    max_d       = max_q;
    mode_d      = mode_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_dark_d  = out_dark_q;
    out_idx_d   = out_idx_q;
    if (in_valid) begin
      min_d  = min_new;
      max_d  = max_new;
      mode_d = mode_eff;
      if (last_beat) begin
        bcnt_d      = '0;
        cell_d      = cell_eff + CNT_W'(1);
        out_valid_d = 1'b1;
        out_data_d  = sel_new;
        out_dark_d  = dark_chain[CH_NUM];
        out_idx_d   = cell_eff;
      end else begin
        bcnt_d = bcnt_eff + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt_q      <= '0;
      cell_q      <= '0;
      min_q       <= '0;
      max_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dark_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      bcnt_q      <= bcnt_d;
      cell_q      <= cell_d;
      min_q       <= min_d;
      max_q       <= max_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dark_q  <= out_dark_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_dark     = out_dark_q;
  assign out_cell_idx = out_idx_q;

endmodule

// File: tb/tb_cell_minmax_stat.sv
// Directed bench for cell_minmax_stat: a CELL_LEN=4 instance and a CELL_LEN=1
// instance share one input stream; each scenario checks the relevant instance.
module tb_cell_minmax_stat;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mode;
  logic        in_sync;
  logic        in_valid;
  logic [23:0] in_data;

  logic        o4_valid, o1_valid;
  logic [23:0] o4_data, o1_data;
  logic [7:0]  o4_dark, o1_dark;
  logic [7:0]  o4_idx, o1_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cell_minmax_stat #(.CH_NUM(3), .CH_W(8), .CELL_LEN(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .resetn(resetn), .mode(mode), .in_sync(in_sync),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(o4_valid), .out_data(o4_data), .out_dark(o4_dark), .out_cell_idx(o4_idx)
  );

  cell_minmax_stat #(.CH_NUM(3), .CH_W(8), .CELL_LEN(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .resetn(resetn), .mode(mode), .in_sync(in_sync),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(o1_valid), .out_data(o1_data), .out_dark(o1_dark), .out_cell_idx(o1_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of input, then return just after the capturing edge.
  task automatic beat(input logic [23:0] d, input logic v, input logic s);
    in_data  = d;
    in_valid = v;
    in_sync  = s;
    tick();
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic res4(input string tag, input logic [23:0] d, input logic [7:0] dk, input logic [7:0] idx);
    chk({tag, "_valid"}, 32'(o4_valid), 32'd1);
    chk({tag, "_data"},  32'(o4_data),  32'(d));
    chk({tag, "_dark"},  32'(o4_dark),  32'(dk));
    chk({tag, "_idx"},   32'(o4_idx),   32'(idx));
  endtask

  task automatic res1(input string tag, input logic [23:0] d, input logic [7:0] dk, input logic [7:0] idx);
    chk({tag, "_valid"}, 32'(o1_valid), 32'd1);
    chk({tag, "_data"},  32'(o1_data),  32'(d));
    chk({tag, "_dark"},  32'(o1_dark),  32'(dk));
    chk({tag, "_idx"},   32'(o1_idx),   32'(idx));
  endtask

  logic [23:0] pix [0:3];
  logic [23:0] rpix [0:3];
  logic [7:0]  c8;
  logic [7:0]  exp_dark;

  initial begin
    pix[0] = 24'h102030; pix[1] = 24'h0A4005; pix[2] = 24'h30100F; pix[3] = 24'h202020;
    rpix[0] = 24'h405060; rpix[1] = 24'h504030; rpix[2] = 24'h454545; rpix[3] = 24'h603A50;

    resetn = 1'b0; mode = 2'd0; in_sync = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_valid", 32'(o4_valid), 32'd0);
    chk("rst_data",  32'(o4_data),  32'd0);
    chk("rst_dark",  32'(o4_dark),  32'd0);
    chk("rst_idx",   32'(o4_idx),   32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Mode 0, continuous
    mode = 2'd0;
    for (int b = 0; b < 3; b++) begin
      beat(pix[b], 1'b1, 1'b0);
      chk("min_nostrobe", 32'(o4_valid), 32'd0);
    end
    beat(pix[3], 1'b1, 1'b0);
    res4("min", 24'h0A1005, 8'h05, 8'd0);
    tick();
    chk("hold_valid", 32'(o4_valid), 32'd0);
    chk("hold_data",  32'(o4_data),  32'h0A1005);

    // Mode 1
    mode = 2'd1;
    for (int b = 0; b < 4; b++) beat(pix[b], 1'b1, 1'b0);
    res4("max", 24'h304030, 8'h30, 8'd1);

    // Mode 2 latched on beat 0, toggled to 0 afterwards
    mode = 2'd2;
    beat(pix[0], 1'b1, 1'b0);
    mode = 2'd0;
    for (int b = 1; b < 4; b++) beat(pix[b], 1'b1, 1'b0);
    res4("range", 24'h26302B, 8'h26, 8'd2);

    // Gapped input: three idle cycles between beats
    mode = 2'd0;
    for (int b = 0; b < 4; b++) begin
      beat(pix[b], 1'b1, 1'b0);
      if (b == 3) res4("gap", 24'h0A1005, 8'h05, 8'd3);
      else chk("gap_beat_nostrobe", 32'(o4_valid), 32'd0);
      for (int g = 0; g < 3; g++) begin
        tick();
        chk("gap_idle_nostrobe", 32'(o4_valid), 32'd0);
      end
    end

    // Sync after two beats discards the partial cell
    beat(24'h000000, 1'b1, 1'b0);
    beat(24'h000000, 1'b1, 1'b0);
    beat(24'h000000, 1'b0, 1'b1);
    chk("sync_nostrobe", 32'(o4_valid), 32'd0);
    beat(24'hFFFFFF, 1'b1, 1'b0);
    beat(24'hFFFFFF, 1'b1, 1'b0);
    beat(24'h01FF02, 1'b1, 1'b0);
    chk("sync_pre_nostrobe", 32'(o4_valid), 32'd0);
    beat(24'hFFFFFF, 1'b1, 1'b0);
    res4("sync", 24'h01FF02, 8'h01, 8'd0);

    // Sync together with the last beat: that beat becomes beat 0 of a new cell
    mode = 2'd1;
    for (int b = 0; b < 3; b++) beat(24'h111111, 1'b1, 1'b0);
    beat(24'h222222, 1'b1, 1'b1);
    chk("synclast_nostrobe", 32'(o4_valid), 32'd0);
    beat(24'h030303, 1'b1, 1'b0);
    beat(24'h040404, 1'b1, 1'b0);
    chk("synclast_pre_nostrobe", 32'(o4_valid), 32'd0);
    beat(24'h050505, 1'b1, 1'b0);
    res4("synclast", 24'h222222, 8'h22, 8'd0);

    // 260 back-to-back cells: index wraps, strobe every 4th cycle exactly
    mode = 2'd0;
    for (int c = 0; c < 260; c++) begin
      c8 = 8'(c);
      for (int b = 0; b < 4; b++) begin
        beat({c8, 8'(b * 16 + 1), 8'(200 - b)}, 1'b1, (c == 0 && b == 0));
        if (b == 3) begin
          exp_dark = (c8 < 8'd1) ? c8 : 8'd1;
          res4("stream", {c8, 8'h01, 8'hC5}, exp_dark, c8);
        end else begin
          chk("stream_nostrobe", 32'(o4_valid), 32'd0);
        end
      end
    end

    // Reset asserted at beat 2 of a cell
    beat(24'h000000, 1'b1, 1'b0);
    beat(24'h000000, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 32'(o4_valid), 32'd0);
    chk("midrst_data",  32'(o4_data),  32'd0);
    chk("midrst_dark",  32'(o4_dark),  32'd0);
    chk("midrst_idx",   32'(o4_idx),   32'd0);
    chk("midrst1_data", 32'(o1_data),  32'd0);
    for (int i = 0; i < 3; i++) begin
      beat(24'h000000, 1'b1, 1'b0);
      chk("inrst_valid", 32'(o4_valid), 32'd0);
      chk("inrst_data",  32'(o4_data),  32'd0);
    end
    resetn = 1'b1;
    for (int b = 0; b < 3; b++) begin
      beat(rpix[b], 1'b1, 1'b0);
      chk("postrst_nostrobe", 32'(o4_valid), 32'd0);
    end
    beat(rpix[3], 1'b1, 1'b0);
    res4("postrst", 24'h403A30, 8'h30, 8'd0);

    // CELL_LEN=1 instance: one result per valid beat, range is zero
    mode = 2'd2;
    beat(24'h123456, 1'b1, 1'b1);
    res1("len1_r0", 24'h000000, 8'h00, 8'd0);
    beat(24'hABCDEF, 1'b1, 1'b0);
    res1("len1_r1", 24'h000000, 8'h00, 8'd1);
    tick();
    chk("len1_idle", 32'(o1_valid), 32'd0);
    mode = 2'd0;
    beat(24'h70605A, 1'b1, 1'b0);
    res1("len1_min", 24'h70605A, 8'h5A, 8'd2);
    mode = 2'd1;
    beat(24'h0F0E0D, 1'b1, 1'b0);
    res1("len1_max", 24'h0F0E0D, 8'h0D, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_minmax_stat.md
Name: cell_minmax_stat

Overview:
- Parametrised per-cell pixel statistics engine for the dehaze/dark-channel pipeline.
- Accumulates CELL_LEN valid pixels of CH_NUM channels each and emits one result per cell.
- Each result carries a per-channel min, max or range (selected by mode) plus a cross-channel minimum (dark value).
- Tolerates gaps in in_valid and can be realigned mid-stream by a sync pulse.

Parameters:
- CH_NUM, 3, number of colour channels packed in one pixel word.
- CH_W, 8, bits per channel.
- CELL_LEN, 24, valid pixels per cell; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of the beat counter and the cell index counter.

Ports:
- clk  in  1  rising-edge system clock, 148.5 MHz.
- resetn  in  1  reset, asynchronous, active-low.
- mode  in  2  statistic select: 0 min, 1 max, 2 range (max-min), 3 reserved (behaves as 0).
- in_sync  in  1  synchronous cell restart; discards any partial cell.
- in_valid  in  1  pixel qualifier.
- in_data  in  CH_NUM*CH_W  pixel; channel k occupies bits [k*CH_W +: CH_W].
- out_valid  out  1  one-cycle result strobe.
- out_data  out  CH_NUM*CH_W  per-channel statistic, same packing as in_data.
- out_dark  out  CH_W  minimum across channels of out_data.
- out_cell_idx  out  CNT_W  index of the cell just emitted since last sync/reset.

Behaviour:
- Reset (resetn low, async): out_valid=0, out_data=0, out_dark=0, out_cell_idx=0. Internal beat counter, min/max accumulators, latched mode and cell counter all clear. Reset asserted mid-cell discards the partial cell; no output is produced for it.
- Beat counter bcnt runs 0..CELL_LEN-1 and advances only on in_valid. A cycle with in_valid=0 holds all state, so gaps do not break a cell.
- First beat (bcnt==0): load min_acc=max_acc=in_data per channel and latch mode into mode_q. mode changes mid-cell are ignored.
- Later beats: per channel, min_acc=min(min_acc,in), max_acc=max(max_acc,in). Comparisons are unsigned, CH_W bits.
- Last beat (bcnt==CELL_LEN-1): the result includes the current beat. Registered outputs update on the next rising edge: latency 1 cycle from the last valid beat. bcnt wraps to 0.
  - out_data = min (mode_q 0/3), max (1), or max-min (2). Range is non-negative and never wraps.
  - out_dark = unsigned min over the CH_NUM channels of the selected out_data.
  - out_cell_idx = cell count before increment. The cell counter then increments and wraps modulo 2**CNT_W.
- out_valid is high exactly one cycle per completed cell; otherwise 0. out_data, out_dark and out_cell_idx hold their last value while out_valid=0.
- Back-to-back cells with continuous in_valid produce one out_valid every CELL_LEN cycles, with no bubble.
- CELL_LEN==1: every valid beat yields a result one cycle later. Mode is latched per beat; range is 0.
- in_sync high: bcnt and the cell counter go to 0 and the partial cell is discarded.
  - in_sync and in_valid in the same cycle: the beat is taken as beat 0 of a new cell.
  - in_sync on the cycle a last beat arrives: the last beat is discarded, no out_valid follows, and the beat is not re-used as beat 0 unless in_valid is high (per rule above, in_sync+in_valid makes it beat 0 of a new cell).
- A result strobe already scheduled (last beat in the previous cycle) is still emitted even if in_sync or new data arrive.
- mode==3 is treated as 0; no error flag.

Test Plan:
- CELL_LEN=4, mode 0: pixels 0x102030, 0x0A4005, 0x30100F, 0x202020 continuous -> one cycle after beat 4, out_valid=1, out_data=0x0A1005, out_dark=0x05, out_cell_idx=0.
- Same pixels, mode 1 then mode 2 (mode toggled to 0 mid-cell) -> mode 1 gives out_data=0x304030, out_dark=0x30. Mode 2 gives 0x26302B, out_dark=0x26. The mid-cell toggle has no effect.
- Gapped input: same 4 pixels with in_valid low 3 cycles between each -> identical result to the first scenario, strobe one cycle after the 4th valid beat, exactly one strobe.
- in_sync after 2 beats, then 4 fresh beats all 0xFFFFFF except one 0x01FF02 -> the partial cell is dropped. A single strobe gives out_data=0x01FF02, out_dark=0x01, out_cell_idx=0.
- Continuous stream of 260 cells with CNT_W=8 -> out_cell_idx counts 0..255 then 0..3; strobes exactly CELL_LEN cycles apart.
- resetn low at beat 2 of a cell, release, feed a full cell -> all outputs 0 during reset, no spurious strobe, next strobe reflects only post-reset pixels with out_cell_idx=0. Repeat with CELL_LEN=1 -> strobe every valid beat, range mode gives 0.
